// File: rtl/srt_fp_result_packer.sv
// rtl/srt_fp_result_packer.sv - SRT divider back end: normalize, denormalize, round-to-nearest-even and pack binary32 (optional SRT_PACK_FTZ_EN flush-to-zero)
module srt_fp_result_packer #(
  parameter int QW    = 27,
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [QW-1:0]    in_q,
  input  logic             in_sticky,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_sign,
  input  logic [1:0]       in_special,
  input  logic             in_dbz,
  input  logic             in_invalid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_flags
);

  // One guard bit on the working exponent so a round carry out of 511 cannot wrap.
  localparam int XW = EXP_W + 1;
  localparam logic signed [XW-1:0] ONE  = XW'(1);
  localparam logic signed [XW-1:0] MAXE = XW'(255);
  localparam logic [4:0] MAX_RSH = 5'd28;

  typedef enum logic [2:0] {IDLE, NORM, DENORM, ROUND, OUT} state_t;

  state_t                state, state_n;
  logic [QW-1:0]         q_r, q_n;
  logic                  s_r, s_n;
  logic signed [XW-1:0]  exp_r, exp_n;
  logic                  sign_r, sign_n;
  logic [4:0]            cnt_r, cnt_n;
  logic [31:0]           res_r, res_n;
  logic [4:0]            flags_r, flags_n;

  logic signed [XW-1:0]  in_exp_sx;
  logic                  g, r, st, lsb, up, carry, hidden, inexact, tiny;
  logic [24:0]           sum;
  logic [22:0]           frac_rnd;
  logic signed [XW-1:0]  exp_rnd;

  assign in_exp_sx = {in_exp[EXP_W-1], in_exp};

  // Rounding datapath, only consumed in ROUND.
  assign g        = q_r[2];
  assign r        = q_r[1];
  assign st       = q_r[0] | s_r;
  assign lsb      = q_r[3];
  assign up       = g & (r | st | lsb);
  assign sum      = {1'b0, q_r[26:3]} + {24'd0, up};
  assign carry    = sum[24];
  assign hidden   = carry | sum[23];
  assign frac_rnd = carry ? 23'd0 : sum[22:0];
  assign exp_rnd  = carry ? exp_r + ONE : exp_r;
  assign inexact  = g | r | st;
  assign tiny     = ~q_r[26];

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == OUT);
  assign out_result = res_r;
  assign out_flags  = flags_r;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      q_r     <= '0;
      s_r     <= 1'b0;
      exp_r   <= '0;
      sign_r  <= 1'b0;
      cnt_r   <= '0;
      res_r   <= '0;
      flags_r <= '0;
    end else begin
      state   <= state_n;
      q_r     <= q_n;
      s_r     <= s_n;
      exp_r   <= exp_n;
      sign_r  <= sign_n;
      cnt_r   <= cnt_n;
      res_r   <= res_n;
      flags_r <= flags_n;
    end
  end

  // Next-state and next-datapath logic; everything holds unless a state moves it.
  always_comb begin
    state_n = state;
    q_n     = q_r;
    s_n     = s_r;
    exp_n   = exp_r;
    sign_n  = sign_r;
    cnt_n   = cnt_r;
    res_n   = res_r;
    flags_n = flags_r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          q_n     = in_q;
          s_n     = in_sticky;
          exp_n   = in_exp_sx;
          sign_n  = in_sign;
          cnt_n   = '0;
          flags_n = {in_invalid, in_dbz, 3'b000};
          if (in_special == 2'b11) begin
            res_n   = 32'h7FC00000;
            state_n = OUT;
          end else if (in_special == 2'b10) begin
            res_n   = {in_sign, 31'h7F800000};
            state_n = OUT;
          end else if (in_special == 2'b01 || in_q == '0) begin
            res_n   = {in_sign, 31'd0};
            state_n = OUT;
          end else begin
`ifdef SRT_PACK_FTZ_EN
            state_n = NORM;
`else
            // A negative exponent can never need a left shift, so go straight to
            // right-shifting and save the NORM decision cycle.
            state_n = (in_exp_sx < ONE) ? DENORM : NORM;
`endif
          end
        end
      end
      NORM: begin
        if (!q_r[26] && exp_r > ONE) begin
          q_n   = q_r << 1;
          exp_n = exp_r - ONE;
        end else if (exp_r < ONE) begin
`ifdef SRT_PACK_FTZ_EN
          res_n   = {sign_r, 31'd0};
          flags_n = 5'b00011;
          state_n = OUT;
`else
          state_n = DENORM;
`endif
        end else begin
          state_n = ROUND;
        end
      end
      DENORM: begin
        if (exp_r < ONE) begin
          if (cnt_r == MAX_RSH) begin
            // Everything has already been shifted out; fold the rest into sticky.
            q_n   = '0;
            s_n   = s_r | (|q_r);
            exp_n = ONE;
          end else begin
            q_n   = q_r >> 1;
            s_n   = s_r | q_r[0];
            exp_n = exp_r + ONE;
            cnt_n = cnt_r + 5'd1;
          end
        end else begin
          state_n = ROUND;
        end
      end
      ROUND: begin
        state_n = OUT;
        if (exp_rnd >= MAXE) begin
          res_n   = {sign_r, 31'h7F800000};
          flags_n = 5'b00101;
`ifdef SRT_PACK_FTZ_EN
        end else if (!hidden) begin
          res_n   = {sign_r, 31'd0};
          flags_n = 5'b00011;
`endif
        end else begin
          res_n   = {sign_r, (hidden ? exp_rnd[7:0] : 8'd0), frac_rnd};
          flags_n = {3'b000, tiny & inexact, inexact};
        end
      end
      OUT: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/srt_fp_result_packer.md
Name: srt_fp_result_packer

Overview:
- Back end of the SRT single-precision divider; the inverse of the operand unpack/normalize front end.
- Takes the raw SRT quotient mantissa, the biased result exponent and the sign, and packs them into an IEEE-754 binary32 result with exception flags.
- Left-normalizes one bit per cycle, right-shifts into subnormal range one bit per cycle, then rounds to nearest even.
- valid/ready handshake on both sides.

Parameters:
- QW, 27, quotient width; q[QW-1] has weight 2^0, q[QW-2:0] are fraction bits. Only 27 is supported for binary32 (23 fraction + G + R + S).
- EXP_W, 10, width of the signed two's-complement biased exponent input.

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input operation valid
- in_ready  out  1  packer can accept an operation
- in_q  in  QW  quotient mantissa
- in_sticky  in  1  remainder nonzero
- in_exp  in  EXP_W  signed biased exponent (ea-eb+127)
- in_sign  in  1  result sign
- in_special  in  2  00 normal, 01 zero, 10 inf, 11 NaN
- in_dbz  in  1  divide-by-zero (with in_special=10)
- in_invalid  in  1  invalid operation (with in_special=11)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  32  packed binary32
- out_flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state IDLE, out_valid 0, out_result 0, out_flags 0. in_ready (= state==IDLE) is 1 after reset.
- Reset mid-operation discards the operation; no output is produced.
- FSM states: IDLE, NORM, DENORM, ROUND, OUT.
- IDLE:
  - Accept on in_valid & in_ready; register all inputs; sticky register S = in_sticky.
  - Special input, or in_q==0: load the final result directly and go to OUT.
    - NaN gives 0x7FC00000 (sign 0).
    - Inf gives {sign,0x7F800000}.
    - Zero / zero quotient gives {sign,31'b0}.
    - Flags: in_invalid and in_dbz pass through; all other flags 0.
  - Otherwise go to NORM.
- NORM, evaluated each cycle:
  - q[26]==0 and exp>1: q<<=1, exp-=1, stay.
  - exp<1: go to DENORM.
  - Else: go to ROUND.
- DENORM, evaluated each cycle:
  - exp<1: q>>=1, S|=shifted-out bit, exp+=1, stay.
  - Else (exp==1): go to ROUND.
  - Right shift is capped at 28 steps; beyond the cap, q is 0 and S is sticky.
- ROUND (1 cycle):
  - Fields: frac=q[25:3], G=q[2], R=q[1], St=q[0]|S, lsb=q[3].
  - Round up when G & (R|St|lsb): 24-bit {q[26],frac} += 1.
  - Carry out of bit 24: mantissa becomes 1.0, exp+=1.
  - inexact = G|R|St.
  - tiny = q[26]==0 before rounding; underflow = tiny & inexact.
  - Exponent field = exp if the rounded hidden bit is 1, else 0. A subnormal rounding up to the hidden bit yields field 1.
  - exp>=255 after rounding: result {sign,0x7F800000}, overflow=1, inexact=1.
  - Register out_result and out_flags; go to OUT.
- OUT:
  - out_valid=1; out_result and out_flags held stable until out_ready.
  - On out_ready: go to IDLE.
  - in_ready=0 throughout; no bypass, so the next operation is accepted in IDLE.
- Latency, counted in clk edges from the accept edge to out_valid rising:
  - Special or zero quotient: 1.
  - Already normalized (q[26]=1, exp in 1..254): 3.
  - Each left or right shift adds 1.
- Simultaneous in_valid during OUT is ignored; in_valid must be held until in_ready.

Optional Feature:
- Macro SRT_PACK_FTZ_EN (flush-to-zero).
- Defined:
  - DENORM is never entered.
  - If exp<1 when NORM finishes: result {sign,31'b0}, underflow=1, inexact=1, straight to OUT.
  - NORM stops at exp==1 as normal; a result with field 0 after rounding is also flushed.
- Undefined: gradual underflow as described above.

Test Plan:
1. in_q=0x6000000, in_exp=127, sign 0 -> out_result 0x3FC00000, flags 0, out_valid 3 cycles after accept.
2. in_q=0x3000000, in_exp=127 -> one NORM shift -> 0x3F400000, latency 4.
3. Rounding:
   - in_q=0x7FFFFFF, in_exp=127 -> carry-out -> 0x40000000, inexact=1.
   - in_q=0x4000004 (tie, lsb 0) -> 0x3F800000, inexact=1.
   - in_q=0x400000C (tie, lsb 1) -> 0x3F800002.
4. Overflow: in_q=0x4000000, in_exp=255 -> 0x7F800000, flags 00101.
5. Subnormal: in_q=0x4000000, in_exp=-2 -> 3 DENORM shifts -> 0x00100000, flags 0, latency 6. With SRT_PACK_FTZ_EN -> 0x00000000, flags 00011.
6. Special and backpressure:
   - in_special=11, in_invalid=1 -> 0x7FC00000, flags 10000, latency 1.
   - Hold out_ready=0 for 5 cycles -> result stable, in_ready 0.
   - Assert rst during NORM -> out_valid 0, in_ready 1 immediately.
